// File: rtl/fir_dec_pkg.sv
// Shared constants and helpers for the FIR decimator:
// default widths, clog2 and the shift/round/saturate scaler.
package fir_dec_pkg;

  localparam int IN_W_DEF  = 17;
  localparam int OUT_W_DEF = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Operates on a 33-bit working value so any input up to
  // 32 bits plus the rounding carry fits without wrapping.
  function automatic logic [32:0] sat_shift(
    input logic [31:0] din,
    input int unsigned sh,
    input int unsigned ow,
    input logic        rnd
  );
    logic [32:0] sum;
    logic [32:0] q;
    logic [32:0] lim;
    sum = {1'b0, din};
    if (rnd && (sh != 0))
      sum = sum + (33'd1 << (sh - 1));
    q   = sum >> sh;
    lim = (33'd1 << ow) - 33'd1;
    return (q > lim) ? lim : q;
  endfunction

endpackage

// File: rtl/fir_dec_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: clock, reset (async, active low), push, pop,
// din, dout, full, empty, level.
module fir_dec_fifo
  import fir_dec_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int LW    = clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int AW = clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [LW-1:0] r_level;
  logic          w_pop;
  logic          w_push;

  assign empty = (r_level == '0);
  assign full  = (r_level == LW'(DEPTH));

  // A push into a full FIFO is legal when the head
  // leaves in the same cycle.
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  assign dout  = empty ? '0 : r_mem[r_rd];
  assign level = r_level;

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      unique case (1'b1)
        (w_push && !w_pop): r_level <= r_level + 1'b1;
        (w_pop && !w_push): r_level <= r_level - 1'b1;
        default:            r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/fir_decimator.sv
// Keeps every DEC_FACTOR-th FIR sample, scales, saturates
// and buffers it for a valid/ready consumer.
// Ports: clock, reset (async, active low), in_valid,
// in_data, ov_clr, out_valid, out_ready, out_data,
// fifo_level, overflow (sticky drop flag).
// Macro FIR_DEC_ROUND_EN: round-half-up before the shift.
module fir_decimator
  import fir_dec_pkg::*;
#(
  parameter int IN_W       = IN_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int DEC_FACTOR = 4,
  parameter int SHIFT      = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [IN_W-1:0]              in_data,
  input  logic                         ov_clr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_W-1:0]             out_data,
  output logic [clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                         overflow
);

  localparam int PH_W =
    (DEC_FACTOR > 1) ? clog2(DEC_FACTOR) : 1;

`ifdef FIR_DEC_ROUND_EN
  localparam logic RND = 1'b1;
`else
  localparam logic RND = 1'b0;
`endif

  logic [PH_W-1:0]  r_phase;
  logic             r_stg_valid;
  logic [OUT_W-1:0] r_stg_data;
  logic             r_overflow;
  logic             w_keep;
  logic [OUT_W-1:0] w_scaled;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_drop;

  assign w_keep = in_valid && (r_phase == '0);

  assign w_scaled = OUT_W'(sat_shift(
    32'(in_data), SHIFT, OUT_W, RND));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_phase     <= '0;
      r_stg_valid <= 1'b0;
      r_stg_data  <= '0;
    end else begin
      if (in_valid) begin
        if (r_phase == PH_W'(DEC_FACTOR - 1))
          r_phase <= '0;
        else
          r_phase <= r_phase + 1'b1;
      end
      r_stg_valid <= w_keep;
      if (w_keep) r_stg_data <= w_scaled;
    end
  end

  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;
  assign w_drop    = r_stg_valid && w_full && !w_pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
    else if (ov_clr) r_overflow <= 1'b0;
  end

  assign overflow = r_overflow;

  fir_dec_fifo #(
    .W     (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (r_stg_valid),
    .pop   (w_pop),
    .din   (r_stg_data),
    .dout  (out_data),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_fir_decimator.sv
// Directed bench for fir_decimator (DEC_FACTOR=4,
// SHIFT=5, OUT_W=8, FIFO_DEPTH=4).
module tb_fir_decimator;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [16:0] in_data;
  logic        ov_clr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  fifo_level;
  logic        overflow;

  int n_cmp;
  int n_err;
  int cnt;
  logic [7:0] got [16];

  fir_decimator dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .ov_clr     (ov_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    ov_clr    = 1'b0;
    out_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    cnt = 0;
  endtask

  task automatic send_kept(input logic [16:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_data = 17'h0AAAA;
    repeat (3) tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int maxc);
    out_ready = 1'b1;
    for (int i = 0; i < maxc; i++) begin
      if (out_valid && cnt < 16) begin
        got[cnt] = out_data;
        cnt++;
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    ov_clr    = 1'b0;
    out_ready = 1'b0;
    #3;
    n_cmp++;
    if ({out_valid, out_data, fifo_level, overflow}
        !== 13'd0) begin
      n_err++;
      $display("FAIL reset_state got v=%b d=%0d l=%0d o=%b want 0",
        out_valid, out_data, fifo_level, overflow);
    end
    tick();
    reset = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({out_valid, fifo_level, overflow} !== 5'd0) begin
      n_err++;
      $display("FAIL reset_idle got v=%b l=%0d o=%b want 0",
        out_valid, fifo_level, overflow);
    end
  endtask

  task automatic test_ramp();
    logic [7:0] exp_v [4];
    exp_v = '{8'd0, 8'd4, 8'd8, 8'd12};
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_data  = 17'(32 * k);
      if (out_valid) begin
        got[cnt] = out_data;
        cnt++;
      end
      tick();
      if (k == 0) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL ramp_lat1 got %b want 0", out_valid);
        end
      end
      if (k == 1) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'd0) begin
          n_err++;
          $display("FAIL ramp_lat2 got v=%b d=%0d want v=1 d=0",
            out_valid, out_data);
        end
      end
    end
    in_valid = 1'b0;
    drain(6);
    n_cmp++;
    if (cnt !== 4) begin
      n_err++;
      $display("FAIL ramp_count got %0d want 4", cnt);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got[i] !== exp_v[i]) begin
        n_err++;
        $display("FAIL ramp_val%0d got %0d want %0d",
          i, got[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_rounding();
    logic [7:0] e48;
`ifdef FIR_DEC_ROUND_EN
    e48 = 8'd2;
`else
    e48 = 8'd1;
`endif
    do_reset();
    send_kept(17'd48);
    send_kept(17'd100);
    drain(6);
    n_cmp++;
    if (cnt !== 2 || got[0] !== e48) begin
      n_err++;
      $display("FAIL round_48 got n=%0d d=%0d want %0d",
        cnt, got[0], e48);
    end
    n_cmp++;
    if (got[1] !== 8'd3) begin
      n_err++;
      $display("FAIL round_100 got %0d want 3", got[1]);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    send_kept(17'h1FFFF);
    send_kept(17'd8160);
    send_kept(17'd8176);
    drain(8);
    n_cmp++;
    if (cnt !== 3) begin
      n_err++;
      $display("FAIL sat_count got %0d want 3", cnt);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (got[i] !== 8'd255) begin
        n_err++;
        $display("FAIL sat_val%0d got %0d want 255", i, got[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int j = 1; j <= 4; j++) send_kept(17'(32 * j));
    tick();
    n_cmp++;
    if (fifo_level !== 3'd4 || out_data !== 8'd1 ||
        overflow !== 1'b0 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_full got l=%0d d=%0d o=%b v=%b want 4 1 0 1",
        fifo_level, out_data, overflow, out_valid);
    end
    send_kept(17'd160);
    n_cmp++;
    if (overflow !== 1'b1 || fifo_level !== 3'd4) begin
      n_err++;
      $display("FAIL bp_drop got o=%b l=%0d want 1 4",
        overflow, fifo_level);
    end
    drain(8);
    n_cmp++;
    if (cnt !== 4) begin
      n_err++;
      $display("FAIL bp_count got %0d want 4", cnt);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got[i] !== 8'(i + 1)) begin
        n_err++;
        $display("FAIL bp_val%0d got %0d want %0d",
          i, got[i], i + 1);
      end
    end
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_err++;
      $display("FAIL bp_sticky got %b want 1", overflow);
    end
    ov_clr = 1'b1;
    tick();
    ov_clr = 1'b0;
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL bp_clr got %b want 0", overflow);
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_v [4];
    exp_v = '{8'd11, 8'd12, 8'd13, 8'd20};
    do_reset();
    for (int j = 10; j <= 13; j++) send_kept(17'(32 * j));
    tick();
    in_valid = 1'b1;
    in_data  = 17'(32 * 20);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    n_cmp++;
    if (fifo_level !== 3'd4 || overflow !== 1'b0 ||
        out_data !== 8'd11) begin
      n_err++;
      $display("FAIL fullpop got l=%0d o=%b d=%0d want 4 0 11",
        fifo_level, overflow, out_data);
    end
    drain(8);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got[i] !== exp_v[i] || cnt !== 4) begin
        n_err++;
        $display("FAIL fullpop_val%0d got %0d n=%0d want %0d n=4",
          i, got[i], cnt, exp_v[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_data = 17'(32 * (k + 1));
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (fifo_level !== 3'd3) begin
      n_err++;
      $display("FAIL mid_pre got l=%0d want 3", fifo_level);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0 ||
        overflow !== 1'b0) begin
      n_err++;
      $display("FAIL mid_async got v=%b l=%0d o=%b want 0",
        out_valid, fifo_level, overflow);
    end
    tick();
    reset = 1'b1;
    tick();
    cnt = 0;
    in_valid = 1'b1;
    in_data  = 17'(32 * 9);
    tick();
    in_valid = 1'b0;
    drain(6);
    n_cmp++;
    if (cnt !== 1 || got[0] !== 8'd9) begin
      n_err++;
      $display("FAIL mid_restart got n=%0d d=%0d want n=1 d=9",
        cnt, got[0]);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cnt   = 0;
    test_reset();
    test_ramp();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_full_pop();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_err);
    $finish;
  end

endmodule
